// File: rtl/conv_wb_pkg.sv
// Shared state type, default word widths and address-width helpers for the
// conv weight/bias sequencer.
package conv_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int W_WIDTH_DEF = 72;
  localparam int B_WIDTH_DEF = 24;

  // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
  function automatic int clog2_f(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << res) < value) res = res + 1;
    end
    return res;
  endfunction

  function automatic int waddr_w_f(input int ch_num, input int kwords);
    return clog2_f(ch_num * kwords);
  endfunction

  function automatic int baddr_w_f(input int ch_num);
    return clog2_f(ch_num);
  endfunction

endpackage

// File: rtl/conv_wb_bank.sv
// Simple dual-port RAM: one write port, one enabled synchronous read port.
// Read data holds while re_i is low; contents are never reset.
module conv_wb_bank #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_wb_sequencer.sv
// Weight/bias store and per-channel kernel sequencer for conv datapaths.
// Define CONV_WB_DBUF_EN for active/shadow double-buffered banks.
module conv_wb_sequencer
  import conv_wb_pkg::*;
#(
  parameter int W_WIDTH  = W_WIDTH_DEF,
  parameter int B_WIDTH  = B_WIDTH_DEF,
  parameter int KWORDS   = 9,
  parameter int CH_NUM   = 32,
  parameter int SLOT_CYC = 18,
  parameter int PASS_NUM = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld_w_valid_i,
  output logic                        ld_w_ready_o,
  input  logic [W_WIDTH-1:0]          ld_w_data_i,
  input  logic                        ld_b_valid_i,
  output logic                        ld_b_ready_o,
  input  logic [B_WIDTH-1:0]          ld_b_data_i,
  input  logic                        start_i,
  input  logic                        hold_i,
  output logic [W_WIDTH-1:0]          weight_o,
  output logic [B_WIDTH-1:0]          bias_o,
  output logic                        w_valid_o,
  output logic [clog2_f(CH_NUM)-1:0]  ch_o,
  output logic                        first_o,
  output logic                        last_o,
  output logic                        loaded_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int CH_W   = baddr_w_f(CH_NUM);
  localparam int SC_W   = clog2_f(SLOT_CYC);
  localparam int PS_W   = clog2_f(PASS_NUM);
  localparam int WA_W   = waddr_w_f(CH_NUM, KWORDS);
  localparam int WDEPTH = CH_NUM * KWORDS;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_CYC - 1);
  localparam logic [SC_W-1:0] KW_LAST = SC_W'(KWORDS - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PASS_NUM - 1);
  localparam logic [WA_W-1:0] WP_LAST = WA_W'(WDEPTH - 1);

  state_e          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [PS_W-1:0] pass_q, pass_d;
  logic [WA_W-1:0] wptr_q, wptr_d;
  logic [CH_W-1:0] bptr_q, bptr_d;
  logic            w_full_q, w_full_d, b_full_q, b_full_d;
  logic            loaded_q, busy_q, done_q, w_valid_q, first_q, last_q;
  logic            rd_seen_q;
  logic [CH_W-1:0] ch_out_q;

  logic            w_beat, b_beat, start_ok, rd_en, bias_rd;
  logic            slot_end, ch_end;
  logic [WA_W-1:0] w_raddr;
  logic [W_WIDTH-1:0] w_sel;
  logic [B_WIDTH-1:0] b_sel;

`ifdef CONV_WB_DBUF_EN
  assign ld_w_ready_o = !w_full_q;
  assign ld_b_ready_o = !b_full_q;
`else
  assign ld_w_ready_o = !w_full_q && !busy_q;
  assign ld_b_ready_o = !b_full_q && !busy_q;
`endif

  assign w_beat   = ld_w_valid_i && ld_w_ready_o;
  assign b_beat   = ld_b_valid_i && ld_b_ready_o;
  assign start_ok = (state_q == ST_IDLE) && start_i && loaded_q;
  assign rd_en    = (state_q == ST_RUN) && !hold_i && (sc_q <= KW_LAST);
  assign bias_rd  = (state_q == ST_RUN) && !hold_i && (sc_q == '0);
  assign slot_end = (sc_q == SC_LAST);
  assign ch_end   = slot_end && (ch_q == CH_LAST);
  assign w_raddr  = WA_W'(int'(ch_q) * KWORDS + int'(sc_q));

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    ch_d     = ch_q;
    pass_d   = pass_q;
    wptr_d   = wptr_q;
    bptr_d   = bptr_q;
    w_full_d = w_full_q;
    b_full_d = b_full_q;

    if (w_beat) begin
      if (wptr_q == WP_LAST) begin
        wptr_d   = '0;
        w_full_d = 1'b1;
      end else begin
        wptr_d = wptr_q + WA_W'(1);
      end
    end
    if (b_beat) begin
      if (bptr_q == CH_LAST) begin
        bptr_d   = '0;
        b_full_d = 1'b1;
      end else begin
        bptr_d = bptr_q + CH_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          sc_d    = '0;
          ch_d    = '0;
          pass_d  = '0;
`ifdef CONV_WB_DBUF_EN
          // The freshly swapped-out bank becomes the new load target.
          w_full_d = 1'b0;
          b_full_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (!hold_i) begin
          if (!slot_end) begin
            sc_d = sc_q + SC_W'(1);
          end else begin
            sc_d = '0;
            if (!ch_end) begin
              ch_d = ch_q + CH_W'(1);
            end else begin
              ch_d = '0;
              if (pass_q == PS_LAST) begin
                pass_d  = '0;
                state_d = ST_DONE;
`ifndef CONV_WB_DBUF_EN
                w_full_d = 1'b0;
                b_full_d = 1'b0;
`endif
              end else begin
                pass_d = pass_q + PS_W'(1);
              end
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sc_q      <= '0;
      ch_q      <= '0;
      pass_q    <= '0;
      wptr_q    <= '0;
      bptr_q    <= '0;
      w_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_valid_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      rd_seen_q <= 1'b0;
      ch_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      ch_q      <= ch_d;
      pass_q    <= pass_d;
      wptr_q    <= wptr_d;
      bptr_q    <= bptr_d;
      w_full_q  <= w_full_d;
      b_full_q  <= b_full_d;
      loaded_q  <= w_full_d && b_full_d;
      busy_q    <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      w_valid_q <= rd_en;
      first_q   <= bias_rd;
      last_q    <= rd_en && (sc_q == KW_LAST) && (ch_q == CH_LAST);
      if (rd_en) rd_seen_q <= 1'b1;
      if (bias_rd) ch_out_q <= ch_q;
    end
  end

`ifdef CONV_WB_DBUF_EN
  logic               bank_q, rsel_q;
  logic [W_WIDTH-1:0] w_rdata [2];
  logic [B_WIDTH-1:0] b_rdata [2];

  // rsel_q follows the bank that produced the held read data, so weight_o
  // does not jump when the banks swap at the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      if (start_ok) bank_q <= !bank_q;
      if (rd_en) rsel_q <= bank_q;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    conv_wb_bank #(.DW(W_WIDTH), .DEPTH(WDEPTH), .AW(WA_W)) u_wbank (
      .clk     (clk),
      .we_i    (w_beat && (bank_q == (gi == 0))),
      .waddr_i (wptr_q),
      .wdata_i (ld_w_data_i),
      .re_i    (rd_en),
      .raddr_i (w_raddr),
      .rdata_o (w_rdata[gi])
    );
    conv_wb_bank #(.DW(B_WIDTH), .DEPTH(CH_NUM), .AW(CH_W)) u_bbank (
      .clk     (clk),
      .we_i    (b_beat && (bank_q == (gi == 0))),
      .waddr_i (bptr_q),
      .wdata_i (ld_b_data_i),
      .re_i    (bias_rd),
      .raddr_i (ch_q),
      .rdata_o (b_rdata[gi])
    );
  end

  assign w_sel = rsel_q ? w_rdata[1] : w_rdata[0];
  assign b_sel = rsel_q ? b_rdata[1] : b_rdata[0];
`else
  conv_wb_bank #(.DW(W_WIDTH), .DEPTH(WDEPTH), .AW(WA_W)) u_wbank (
    .clk     (clk),
    .we_i    (w_beat),
    .waddr_i (wptr_q),
    .wdata_i (ld_w_data_i),
    .re_i    (rd_en),
    .raddr_i (w_raddr),
    .rdata_o (w_sel)
  );
  conv_wb_bank #(.DW(B_WIDTH), .DEPTH(CH_NUM), .AW(CH_W)) u_bbank (
    .clk     (clk),
    .we_i    (b_beat),
    .waddr_i (bptr_q),
    .wdata_i (ld_b_data_i),
    .re_i    (bias_rd),
    .raddr_i (ch_q),
    .rdata_o (b_sel)
  );
`endif

  // RAM outputs are unreset, so mask them until the first read after reset.
  assign weight_o  = rd_seen_q ? w_sel : '0;
  assign bias_o    = rd_seen_q ? b_sel : '0;
  assign w_valid_o = w_valid_q;
  assign ch_o      = ch_out_q;
  assign first_o   = first_q;
  assign last_o    = last_q;
  assign loaded_o  = loaded_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_conv_wb_sequencer.sv
// Randomised and directed bench for conv_wb_sequencer against a step-indexed
// behavioural model (small geometry: 2 channels, 3 words, 5-cycle slots, 2 passes).
module tb_conv_wb_sequencer;

  localparam int WW    = 72;
  localparam int BW    = 24;
  localparam int KW    = 3;
  localparam int CH    = 2;
  localparam int SLOT  = 5;
  localparam int PASS  = 2;
  localparam int NW    = CH * KW;
  localparam int TOTAL = PASS * CH * SLOT;
`ifdef CONV_WB_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ld_w_valid_i = 1'b0;
  logic          ld_w_ready_o;
  logic [WW-1:0] ld_w_data_i = '0;
  logic          ld_b_valid_i = 1'b0;
  logic          ld_b_ready_o;
  logic [BW-1:0] ld_b_data_i = '0;
  logic          start_i = 1'b0;
  logic          hold_i = 1'b0;
  logic [WW-1:0] weight_o;
  logic [BW-1:0] bias_o;
  logic          w_valid_o;
  logic [0:0]    ch_o;
  logic          first_o, last_o, loaded_o, busy_o, done_o;

  always #5 clk = ~clk;

  conv_wb_sequencer #(
    .W_WIDTH(WW), .B_WIDTH(BW), .KWORDS(KW), .CH_NUM(CH),
    .SLOT_CYC(SLOT), .PASS_NUM(PASS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_w_valid_i(ld_w_valid_i), .ld_w_ready_o(ld_w_ready_o), .ld_w_data_i(ld_w_data_i),
    .ld_b_valid_i(ld_b_valid_i), .ld_b_ready_o(ld_b_ready_o), .ld_b_data_i(ld_b_data_i),
    .start_i(start_i), .hold_i(hold_i),
    .weight_o(weight_o), .bias_o(bias_o), .w_valid_o(w_valid_o), .ch_o(ch_o),
    .first_o(first_o), .last_o(last_o), .loaded_o(loaded_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Model: per-bank memories, fill counts, and a run expressed as step index k.
  logic [WW-1:0] m_wmem [2][NW];
  logic [BW-1:0] m_bmem [2][CH];
  int            m_wcnt, m_bcnt, m_act, m_phase, m_k;
  bit            m_wfull, m_bfull;
  logic [WW-1:0] e_weight;
  logic [BW-1:0] e_bias;
  int            e_ch;
  bit            e_wvalid, e_first, e_last;

  int            n_checks = 0, n_fail = 0;
  int            cyc = 0, t_busy = 0, t_done = 0, n_last = 0;
  bit            prev_busy = 1'b0, got_first = 1'b0;
  logic [WW-1:0] first_w = '0;

  task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_bcnt = 0; m_act = 0; m_phase = 0; m_k = 0;
    m_wfull = 1'b0; m_bfull = 1'b0;
    e_weight = '0; e_bias = '0; e_ch = 0;
    e_wvalid = 1'b0; e_first = 1'b0; e_last = 1'b0;
  endtask

  task automatic tick();
    bit loaded_pre, w_rdy, b_rdy;
    int sh, sc, ch;
    loaded_pre = m_wfull && m_bfull;
    w_rdy = !m_wfull && (DBUF || m_phase != 1);
    b_rdy = !m_bfull && (DBUF || m_phase != 1);
    sh = DBUF ? 1 - m_act : 0;
    @(posedge clk);
    cyc++;
    if (ld_w_valid_i && w_rdy) begin
      m_wmem[sh][m_wcnt] = ld_w_data_i;
      m_wcnt++;
      if (m_wcnt == NW) begin m_wcnt = 0; m_wfull = 1'b1; end
    end
    if (ld_b_valid_i && b_rdy) begin
      m_bmem[sh][m_bcnt] = ld_b_data_i;
      m_bcnt++;
      if (m_bcnt == CH) begin m_bcnt = 0; m_bfull = 1'b1; end
    end
    e_wvalid = 1'b0; e_first = 1'b0; e_last = 1'b0;
    case (m_phase)
      0: if (start_i && loaded_pre) begin
        m_phase = 1; m_k = 0;
        if (DBUF) begin m_act = 1 - m_act; m_wfull = 1'b0; m_bfull = 1'b0; end
      end
      1: if (!hold_i) begin
        sc = m_k % SLOT;
        ch = (m_k / SLOT) % CH;
        if (sc < KW) begin
          e_wvalid = 1'b1;
          e_weight = m_wmem[m_act][ch * KW + sc];
          e_first  = (sc == 0);
          e_last   = (sc == KW - 1) && (ch == CH - 1);
        end
        if (sc == 0) begin e_ch = ch; e_bias = m_bmem[m_act][ch]; end
        m_k++;
        if (m_k == TOTAL) begin
          m_phase = 2;
          if (!DBUF) begin m_wfull = 1'b0; m_bfull = 1'b0; end
        end
      end
      default: m_phase = 0;
    endcase
    #1;
    check_eq("weight", weight_o, e_weight);
    check_eq("bias", WW'(bias_o), WW'(e_bias));
    check_eq("w_valid", WW'(w_valid_o), WW'(e_wvalid));
    check_eq("ch", WW'(ch_o), WW'(e_ch));
    check_eq("first", WW'(first_o), WW'(e_first));
    check_eq("last", WW'(last_o), WW'(e_last));
    check_eq("loaded", WW'(loaded_o), WW'(m_wfull && m_bfull));
    check_eq("busy", WW'(busy_o), WW'(m_phase == 1));
    check_eq("done", WW'(done_o), WW'(m_phase == 2));
    check_eq("w_ready", WW'(ld_w_ready_o), WW'(!m_wfull && (DBUF || m_phase != 1)));
    check_eq("b_ready", WW'(ld_b_ready_o), WW'(!m_bfull && (DBUF || m_phase != 1)));
    if (busy_o && !prev_busy) begin
      t_busy = cyc;
      $display("start accepted at cycle %0d", cyc);
    end
    prev_busy = busy_o;
    if (done_o) begin
      t_done = cyc;
      $display("run done at cycle %0d", cyc);
    end
    if (last_o) n_last++;
    if (w_valid_o && !got_first) begin first_w = weight_o; got_first = 1'b1; end
  endtask

  task automatic load_w(input logic [WW-1:0] d);
    ld_w_valid_i = 1'b1; ld_w_data_i = d;
    tick();
    ld_w_valid_i = 1'b0;
  endtask

  task automatic load_b(input logic [BW-1:0] d);
    ld_b_valid_i = 1'b1; ld_b_data_i = d;
    tick();
    ld_b_valid_i = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, input int hold_k, input int hold_len);
    int hc = 0;
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      hold_i = (m_phase == 1) && (m_k == hold_k) && (hc < hold_len);
      if (hold_i) hc++;
      tick();
      n++;
    end
    hold_i = 1'b0;
    if (m_phase != 0) check_eq("run_timeout", WW'(m_phase), '0);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_weight", weight_o, '0);
    check_eq("rst_bias", WW'(bias_o), '0);
    check_eq("rst_w_valid", WW'(w_valid_o), '0);
    check_eq("rst_busy", WW'(busy_o), '0);
    check_eq("rst_loaded", WW'(loaded_o), '0);
    check_eq("rst_done", WW'(done_o), '0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Directed run: weights 01..06, biases A0/B0.
    for (int i = 0; i < CH; i++) load_b(BW'(8'hA0 + 8'h10 * i));
    for (int i = 0; i < NW; i++) load_w(WW'(i + 1));
    n_last = 0; got_first = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
`ifndef CONV_WB_DBUF_EN
    ld_w_valid_i = 1'b1; ld_w_data_i = WW'(8'hFF);
    repeat (3) tick();
    check_eq("ready_busy", WW'(ld_w_ready_o), '0);
    ld_w_valid_i = 1'b0;
`endif
    run_to_idle(100, -1, 0);
    check_eq("run_len", WW'(t_done - t_busy), WW'(TOTAL));
    check_eq("last_cnt", WW'(n_last), WW'(PASS));
    check_eq("first_weight", first_w, WW'(1));
`ifndef CONV_WB_DBUF_EN
    check_eq("ready_after", WW'(ld_w_ready_o), WW'(1));
    check_eq("loaded_after", WW'(loaded_o), '0);
`endif

    // Partial load: start ignored, final beat + start ignored, next start taken.
    for (int i = 0; i < CH; i++) load_b(BW'(8'hA0 + 8'h10 * i));
    for (int i = 0; i < NW - 1; i++) load_w(WW'(i + 1));
    start_i = 1'b1; tick();
    check_eq("start_ign5", WW'(busy_o), '0);
    ld_w_valid_i = 1'b1; ld_w_data_i = WW'(NW); tick(); ld_w_valid_i = 1'b0;
    check_eq("start_ign6", WW'(busy_o), '0);
    tick(); start_i = 1'b0;
    check_eq("start_acc", WW'(busy_o), WW'(1));
    run_to_idle(100, SLOT + 1, 3);
    check_eq("hold_run_len", WW'(t_done - t_busy), WW'(TOTAL + 3));

    // Randomised loads, starts and holds.
    repeat (400) begin
      ld_w_valid_i = 1'($urandom_range(0, 1));
      ld_w_data_i  = WW'({$urandom, $urandom, $urandom});
      ld_b_valid_i = 1'($urandom_range(0, 1));
      ld_b_data_i  = BW'($urandom);
      start_i      = ($urandom_range(0, 3) == 0);
      hold_i       = ($urandom_range(0, 3) == 0);
      tick();
    end
    ld_w_valid_i = 1'b0; ld_b_valid_i = 1'b0; start_i = 1'b0; hold_i = 1'b0;
    run_to_idle(200, -1, 0);

    // Mid-run reset during pass 1.
    n = 0;
    while (!(m_wfull && m_bfull) && n < 50) begin
      ld_w_valid_i = !m_wfull; ld_w_data_i = WW'({$urandom, $urandom, $urandom});
      ld_b_valid_i = !m_bfull; ld_b_data_i = BW'($urandom);
      tick();
      n++;
    end
    ld_w_valid_i = 1'b0; ld_b_valid_i = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check_eq("mid_start", WW'(busy_o), WW'(1));
    n = 0;
    while (m_k < CH * SLOT + 2 && n < 100) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_weight", weight_o, '0);
    check_eq("mid_rst_valid", WW'(w_valid_o), '0);
    check_eq("mid_rst_busy", WW'(busy_o), '0);
    check_eq("mid_rst_loaded", WW'(loaded_o), '0);
    check_eq("mid_rst_done", WW'(done_o), '0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    prev_busy = 1'b0;
    start_i = 1'b1; repeat (3) tick(); start_i = 1'b0;
    check_eq("start_noload", WW'(busy_o), '0);

`ifdef CONV_WB_DBUF_EN
    // Load bank B while bank A runs, then start back-to-back.
    for (int i = 0; i < CH; i++) load_b(BW'(8'hA0 + 8'h10 * i));
    for (int i = 0; i < NW; i++) load_w(WW'(i + 1));
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int i = 0; i < CH; i++) load_b(BW'(8'hC0 + 8'h10 * i));
    for (int i = 0; i < NW; i++) load_w(WW'(8'h11 + i));
    run_to_idle(100, -1, 0);
    check_eq("dbuf_loaded", WW'(loaded_o), WW'(1));
    got_first = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    check_eq("dbuf_b2b", WW'(busy_o), WW'(1));
    run_to_idle(100, -1, 0);
    check_eq("dbuf_first", first_w, WW'(8'h11));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_wb_sequencer.md
Name: conv_wb_sequencer

Overview:
Parametrised weight/bias store and sequencer for convolution layers, generalising the first-layer conv weight feed.
- Preloads CH_NUM kernels of KWORDS words each, plus one bias per channel, through valid/ready load ports.
- On start, replays kernels to the conv datapath: KWORDS words at the head of every SLOT_CYC-cycle channel slot, all channels per pass, PASS_NUM passes.
- Sits between host/DMA loader and the conv_*_top datapath, replacing testbench-driven weight allocation.

Parameters:
W_WIDTH, 72, weight word width (9 taps x 8 bit)
B_WIDTH, 24, bias word width
KWORDS, 9, weight words per channel kernel
CH_NUM, 32, output channels per pass
SLOT_CYC, 18, cycles per channel slot; must be >= KWORDS
PASS_NUM, 10, passes per run (figure tiles)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_w_valid_i  in  1  weight load beat valid
ld_w_ready_o  out  1  weight load accept
ld_w_data_i  in  W_WIDTH  weight load word, channel-major, word-minor order
ld_b_valid_i  in  1  bias load beat valid
ld_b_ready_o  out  1  bias load accept
ld_b_data_i  in  B_WIDTH  bias word, channel order
start_i  in  1  run request, level-sampled
hold_i  in  1  downstream stall, freezes sequencing
weight_o  out  W_WIDTH  current weight word
bias_o  out  B_WIDTH  current channel bias
w_valid_o  out  1  weight_o valid this cycle
ch_o  out  clog2(CH_NUM)  channel index of weight_o/bias_o
first_o  out  1  first word of a channel slot
last_o  out  1  last word of last channel in a pass
loaded_o  out  1  full weight and bias set present
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at run end

Behaviour:
- Reset: all outputs 0; state IDLE; write pointers, counters and full flags 0. Memory contents are not reset; a reload is required after reset, including mid-run reset, which aborts with no done_o.
- Load path:
  - A beat transfers when valid && ready; wptr counts 0..CH_NUM*KWORDS-1 and bptr counts 0..CH_NUM-1.
  - Each pointer wraps to 0 on its final beat and sets w_full or b_full.
  - ld_w_ready_o = !w_full && !busy_o; ld_b_ready_o likewise with b_full.
  - loaded_o = w_full && b_full, registered.
- States:
  - IDLE: start_i is accepted only when loaded_o=1 before the edge; it is otherwise ignored, with no latching. On acceptance: sc=0, ch=0, pass=0, go to RUN, busy_o=1 from the next cycle.
  - RUN:
    - Each cycle with hold_i=0, sc advances; at sc=SLOT_CYC-1, sc wraps and ch advances; at ch=CH_NUM-1, ch wraps and pass advances.
    - After the final slot of pass PASS_NUM-1, go to DONE.
    - With hold_i=1, all counters freeze and w_valid_o=0 in the next cycle.
    - start_i is ignored.
  - DONE: one cycle. done_o=1, busy_o=0, w_full and b_full cleared. Next state IDLE.
- Output timing:
  - Registered, latency 1 from counter state.
  - Counter state (sc<KWORDS, hold_i=0) gives w_valid_o=1 next cycle, with weight_o=mem[ch*KWORDS+sc].
  - First weight appears the cycle after busy_o rises.
  - bias_o and ch_o update at sc=0 and hold for the whole slot.
  - first_o marks sc=0; last_o marks sc=KWORDS-1 with ch=CH_NUM-1.
  - weight_o holds its last value when w_valid_o=0.
- Run length: exactly PASS_NUM*CH_NUM*SLOT_CYC unheld cycles; hold cycles extend it 1:1.
- Simultaneous events: a final load beat and start_i in the same cycle means start is ignored, because loaded_o is still 0. hold_i in the cycle that would enter DONE delays DONE.

Optional Feature:
CONV_WB_DBUF_EN
- Defined: two banks (active and shadow). Loads always target the shadow bank, and ready ignores busy_o.
  - An accepted start swaps banks and clears the shadow full flags at the same edge.
  - A shadow bank loaded during RUN allows back-to-back start in IDLE.
  - DONE does not clear flags.
- Undefined: single bank, behaviour as above.

Decomposition:
- Package conv_wb_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default width constants (W_WIDTH=72, B_WIDTH=24);
  - clog2 helper;
  - address-width localparam formulas.
- Sub-module conv_wb_bank: simple dual-port RAM with one write port, synchronous read and no reset; instantiated for weights and for biases (twice each under CONV_WB_DBUF_EN).

Test Plan:
- CH_NUM=2, KWORDS=3, SLOT_CYC=5, PASS_NUM=2. Load weights 0x01..0x06 and biases 0xA0,0xB0, then start → w_valid_o pattern 11100 per slot. Weight order 01,02,03 / 04,05,06 twice. bias_o 0xA0 then 0xB0. Exactly 2 last_o pulses. done_o exactly 20 cycles after busy_o rises.
- start_i with only 5 of 6 weights loaded → ignored, busy_o stays 0. Sixth beat and start_i in the same cycle → still ignored; start in the next cycle is accepted.
- hold_i high 3 cycles at sc=1 of ch=1 → weight 05 delayed 3 cycles, w_valid_o=0 during hold, done_o 23 cycles after start.
- rst_n low mid-run at pass 1 → all outputs 0 immediately, loaded_o=0, no done_o. start without reload is ignored.
- Load attempt while busy → ld_w_ready_o=0 and memory unchanged. After done_o, ready=1 and loaded_o=0.
- CONV_WB_DBUF_EN: load bank B (0x11..0x16) during run of bank A → second start immediately after DONE streams 0x11..0x16.
